// File: rtl/demux4_buf_pkg.sv
// Shared constants for the buffered 1-to-4 demultiplexer: channel count,
// select width and the select encodings.
package demux4_buf_pkg;

    localparam int CH_NUM = 4;
    localparam int SEL_W  = 2;

    localparam logic [SEL_W-1:0] CH0 = 2'b00;
    localparam logic [SEL_W-1:0] CH1 = 2'b01;
    localparam logic [SEL_W-1:0] CH2 = 2'b10;
    localparam logic [SEL_W-1:0] CH3 = 2'b11;

    // One-hot decode of a destination select.
    function automatic logic [CH_NUM-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        logic [CH_NUM-1:0] oh;
        oh = '0;
        case (sel)
            CH0:     oh = 4'b0001;
            CH1:     oh = 4'b0010;
            CH2:     oh = 4'b0100;
            CH3:     oh = 4'b1000;
            default: oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/demux_chan_fifo.sv
// Per-channel first-word-fall-through FIFO with synchronous flush.
// Counts and pointers reset asynchronously; storage is never reset.
module demux_chan_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign valid   = (count != '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & valid;
    assign rdata   = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage has no reset; a flushed write is harmless since pointers clear.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/demux4_buf.sv
// Buffered 1-to-4 demux: routes a valid/ready stream to one of four FWFT
// channel FIFOs so a stalled consumer only blocks its own channel.
module demux4_buf
    import demux4_buf_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic [WIDTH-1:0]        in_data,
    output logic [CH_NUM-1:0]       out_valid,
    input  logic [CH_NUM-1:0]       out_ready,
    output logic [CH_NUM*WIDTH-1:0] out_data,
    output logic                    busy
);

    // Handshake: a word transfers on a rising edge where valid & ready are
    // both 1; the producer holds sel/data stable while valid=1 and ready=0.
    // in_ready deliberately ignores out_ready, so a full channel stays
    // not-ready even in a cycle where it pops.
    logic [CH_NUM-1:0] full_vec;
    logic [CH_NUM-1:0] push_vec;

    assign in_ready = ~full_vec[in_sel] & ~flush;
    assign push_vec = (in_valid & in_ready) ? sel_onehot(in_sel) : '0;
    assign busy     = |out_valid;

    for (genvar k = 0; k < CH_NUM; k++) begin : g_chan
        demux_chan_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rstn  (rstn),
            .flush (flush),
            .push  (push_vec[k]),
            .wdata (in_data),
            .pop   (out_ready[k]),
            .rdata (out_data[k*WIDTH +: WIDTH]),
            .valid (out_valid[k]),
            .full  (full_vec[k])
        );
    end

endmodule

// File: tb/tb_demux4_buf.sv
// Directed bench for demux4_buf: a vector table for single-cycle behaviour
// plus hand-written sequences for wrap/order, flush and async reset.
module tb_demux4_buf;
    import demux4_buf_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;

    logic                    clk = 1'b0;
    logic                    rstn = 1'b0;
    logic                    flush = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [SEL_W-1:0]        in_sel = '0;
    logic [WIDTH-1:0]        in_data = '0;
    logic [CH_NUM-1:0]       out_valid;
    logic [CH_NUM-1:0]       out_ready = '0;
    logic [CH_NUM*WIDTH-1:0] out_data;
    logic                    busy;

    int checks = 0;
    int failures = 0;
    logic [WIDTH-1:0] exp_q[$];

    demux4_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             in_valid;
        logic [1:0]       sel;
        logic [31:0]      data;
        logic [3:0]       out_ready;
        logic             exp_ready;
        logic [3:0]       exp_valid;
        logic [127:0]     exp_data;
    } vec_t;

    vec_t vecs[15];

    function automatic logic [127:0] pack4(input logic [31:0] d3, d2, d1, d0);
        return {d3, d2, d1, d0};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [1:0] sel, input logic [31:0] d,
                         input logic [3:0] ordy);
        in_valid  = iv;
        in_sel    = sel;
        in_data   = d;
        out_ready = ordy;
    endtask

    initial begin
        // Rows: inputs for this cycle, outputs expected before its clock edge.
        vecs[0]  = '{1, CH2, 32'hDEADBEEF, 4'b0000, 1, 4'b0000, pack4(0, 0, 0, 0)};
        vecs[1]  = '{0, CH2, 32'h0,        4'b0100, 1, 4'b0100, pack4(0, 32'hDEADBEEF, 0, 0)};
        vecs[2]  = '{0, CH2, 32'h0,        4'b0000, 1, 4'b0000, pack4(0, 0, 0, 0)};
        vecs[3]  = '{1, CH1, 32'h1,        4'b0000, 1, 4'b0000, pack4(0, 0, 0, 0)};
        vecs[4]  = '{1, CH1, 32'h2,        4'b0000, 1, 4'b0010, pack4(0, 0, 32'h1, 0)};
        vecs[5]  = '{1, CH1, 32'h3,        4'b0000, 0, 4'b0010, pack4(0, 0, 32'h1, 0)};
        vecs[6]  = '{1, CH0, 32'h3,        4'b0000, 1, 4'b0010, pack4(0, 0, 32'h1, 0)};
        vecs[7]  = '{0, CH1, 32'h0,        4'b0010, 0, 4'b0011, pack4(0, 0, 32'h1, 32'h3)};
        vecs[8]  = '{0, CH1, 32'h0,        4'b0011, 1, 4'b0011, pack4(0, 0, 32'h2, 32'h3)};
        vecs[9]  = '{0, CH0, 32'h0,        4'b0000, 1, 4'b0000, pack4(0, 0, 0, 0)};
        vecs[10] = '{1, CH0, 32'hA,        4'b0000, 1, 4'b0000, pack4(0, 0, 0, 0)};
        vecs[11] = '{1, CH1, 32'hB,        4'b0001, 1, 4'b0001, pack4(0, 0, 0, 32'hA)};
        vecs[12] = '{0, CH1, 32'h0,        4'b0000, 1, 4'b0010, pack4(0, 0, 32'hB, 0)};
        vecs[13] = '{0, CH1, 32'h0,        4'b0010, 1, 4'b0010, pack4(0, 0, 32'hB, 0)};
        vecs[14] = '{0, CH1, 32'h0,        4'b0000, 1, 4'b0000, pack4(0, 0, 0, 0)};

        // Reset held for 3 cycles with a pending producer.
        drive(1, CH0, 32'h1234_5678, 4'b1111);
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid", 128'(out_valid), 128'(4'b0000));
        check("rst_busy",  128'(busy), 128'(1'b0));
        check("rst_data",  out_data, 128'h0);
        drive(0, CH0, 32'h0, 4'b0000);
        rstn = 1'b1;
        for (int s = 0; s < CH_NUM; s++) begin
            in_sel = 2'(s);
            #1;
            check("rst_in_ready", 128'(in_ready), 128'(1'b1));
        end

        // Table: single route, full/backpressure, concurrency.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(vecs[i].in_valid, vecs[i].sel, vecs[i].data, vecs[i].out_ready);
            #1;
            check($sformatf("v%0d_in_ready", i),  128'(in_ready),  128'(vecs[i].exp_ready));
            check($sformatf("v%0d_out_valid", i), 128'(out_valid), 128'(vecs[i].exp_valid));
            check($sformatf("v%0d_out_data", i),  out_data,        vecs[i].exp_data);
            check($sformatf("v%0d_busy", i),      128'(busy),      128'(|vecs[i].exp_valid));
        end

        // Wrap/order: stream 0x10..0x17 into ch3 with out_ready[3] toggling.
        begin
            int  sent = 0;
            int  got = 0;
            bit  tog = 1'b0;
            for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
                @(negedge clk);
                drive(sent < 8, CH3, 32'h10 + 32'(sent), {tog, 3'b000});
                tog = ~tog;
                #1;
                if (out_valid[3] && out_ready[3]) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL wrap_extra act=%h exp=none", out_data[127:96]);
                    end else begin
                        check("wrap_order", 128'(out_data[127:96]), 128'(exp_q.pop_front()));
                    end
                    got++;
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back(in_data);
                    sent++;
                end
            end
            check("wrap_count", 128'(got), 128'(8));
            check("wrap_q_empty", 128'(exp_q.size()), 128'(0));
            @(negedge clk);
            drive(0, CH0, 32'h0, 4'b0000);
            #1;
            check("wrap_drained", 128'(out_valid), 128'(4'b0000));
        end

        // Flush: fill ch0 and ch2, then flush with a push and pops pending.
        @(negedge clk); drive(1, CH0, 32'h50, 4'b0000);
        @(negedge clk); drive(1, CH2, 32'h60, 4'b0000);
        @(negedge clk);
        drive(1, CH0, 32'h99, 4'b1111);
        flush = 1'b1;
        #1;
        check("flush_in_ready", 128'(in_ready), 128'(1'b0));
        check("flush_pre_valid", 128'(out_valid), 128'(4'b0101));
        check("flush_pre_data", out_data, pack4(0, 32'h60, 0, 32'h50));
        @(negedge clk);
        flush = 1'b0;
        drive(0, CH0, 32'h0, 4'b0000);
        #1;
        check("flush_valid", 128'(out_valid), 128'(4'b0000));
        check("flush_busy", 128'(busy), 128'(1'b0));
        check("flush_in_ready_back", 128'(in_ready), 128'(1'b1));

        // Refill, then drop reset between clock edges.
        @(negedge clk); drive(1, CH1, 32'h70, 4'b0000);
        @(negedge clk); drive(0, CH1, 32'h0, 4'b0000);
        #1;
        check("refill_valid", 128'(out_valid), 128'(4'b0010));
        check("refill_data", out_data, pack4(0, 0, 32'h70, 0));
        #1 rstn = 1'b0;
        #1;
        check("async_rst_valid", 128'(out_valid), 128'(4'b0000));
        check("async_rst_busy", 128'(busy), 128'(1'b0));
        check("async_rst_data", out_data, 128'h0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("post_rst_in_ready", 128'(in_ready), 128'(1'b1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
